// File: rtl/tx_arbiter_pkg.sv
// tx_arbiter_pkg: shared state type and widths for the UART transmit arbiter.
package tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SEND, RELEASE} tx_arb_state_t;
  localparam int DATA_W = 8;
  localparam int MAX_REQ = 8;
endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request scanning up from last+1 with wrap.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     winner,
  output logic               any
);
  // Scanning from the farthest candidate down lets the nearest one overwrite.
  always_comb begin
    winner = last;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[(int'(last) + i) % NUM_REQ]) winner = IDW'((int'(last) + i) % NUM_REQ);
  end
  assign any = |req;
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one UART tx (Send/Din/Sent) among NUM_REQ byte requesters.
// Define TX_ARBITER_TIMEOUT_EN to abort a SEND that waits TIMEOUT_CYCLES without Sent.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 120000,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  tx_send,
  output logic [DATA_W-1:0]     tx_din,
  input  logic                  tx_sent,
  output logic                  timeout_err
);
  tx_arb_state_t r_state, w_state;
  logic r_send, w_send, r_terr, w_terr, w_any, w_timeout;
  logic [DATA_W-1:0] r_din, w_din;
  logic [NUM_REQ-1:0] r_ack, w_ack;
  logic [IDW-1:0] r_id, w_id, r_last, w_last, w_win;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req(req),
    .last(r_last),
    .winner(w_win),
    .any(w_any)
  );

`ifdef TX_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  assign w_timeout = (r_state == SEND) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= (r_state == SEND) ? r_cnt + 1'b1 : '0;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state = r_state;
    w_send = r_send;
    w_din = r_din;
    w_ack = '0;
    w_id = r_id;
    w_last = r_last;
    w_terr = 1'b0;
    if (r_state == IDLE && w_any) begin
      w_state = SEND;
      w_send = 1'b1;
      w_id = w_win;
      w_din = req_data[DATA_W*int'(w_win) +: DATA_W];
    end
    // Sent wins over a simultaneous timeout, so the error flag only marks true aborts.
    if (r_state == SEND && (tx_sent || w_timeout)) begin
      w_state = RELEASE;
      w_send = 1'b0;
      w_ack = NUM_REQ'(1) << r_id;
      w_last = r_id;
      w_terr = !tx_sent;
    end
    if (r_state == RELEASE && !tx_sent) w_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_send <= 1'b0;
      r_din <= '0;
      r_ack <= '0;
      r_id <= '0;
      r_last <= IDW'(NUM_REQ - 1);
      r_terr <= 1'b0;
    end else begin
      r_state <= w_state;
      r_send <= w_send;
      r_din <= w_din;
      r_ack <= w_ack;
      r_id <= w_id;
      r_last <= w_last;
      r_terr <= w_terr;
    end
  end

  assign ack = r_ack;
  assign grant_id = r_id;
  assign busy = (r_state != IDLE);
  assign tx_send = r_send;
  assign tx_din = r_din;
  assign timeout_err = r_terr;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed stimulus against a transaction-level arbiter model plus a simple tx responder.
module tb_tx_arbiter;
  localparam int N = 2;
`ifdef TX_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, tx_sent = 1'b0;
  logic [N-1:0] req = '0, rearm = '0, ack;
  logic [8*N-1:0] req_data = '0;
  logic [0:0] grant_id;
  logic busy, tx_send, timeout_err;
  logic [7:0] tx_din;
  int checks = 0, errors = 0;
  int hold = 1;
  bit never = 1'b0;
  logic [7:0] sent_q[$];
  int cyc = 0, ack_cyc = 0, send_cyc = 0, gap = 0, to_gap = 0, ack_cnt = 0;

  tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .grant_id(grant_id),
    .busy(busy),
    .tx_send(tx_send),
    .tx_din(tx_din),
    .tx_sent(tx_sent),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tx responder: Sent rises 20 cycles into Send, falls `hold` cycles after Send drops.
  int scnt = 0, rcnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      tx_sent = 1'b0;
      scnt = 0;
      rcnt = 0;
    end else if (tx_send) begin
      rcnt = 0;
      scnt++;
      if (scnt >= 20 && !never) tx_sent = 1'b1;
    end else begin
      scnt = 0;
      if (tx_sent) begin
        rcnt++;
        if (rcnt >= hold) begin
          tx_sent = 1'b0;
          rcnt = 0;
        end
      end
    end
  end

  // Arbiter model: phase 0 waiting, 1 byte on the wire, 2 waiting for Sent to clear.
  int ph = 0, m_id = 0, m_last = N - 1, tcnt = 0;
  logic m_send = 1'b0, m_terr = 1'b0, p_send = 1'b0, p_ack = 1'b0, p_terr = 1'b0;
  logic [7:0] m_din = '0;
  logic [N-1:0] m_ack = '0;
  always @(posedge clk) begin
    if (reset) begin
      ph = 0; m_send = 0; m_din = 0; m_ack = 0; m_id = 0; m_last = N - 1; m_terr = 0;
    end else begin
      m_ack = 0;
      m_terr = 0;
      if (ph == 0 && req != 0) begin
        for (int k = 1; k <= N; k++)
          if (req[(m_last + k) % N]) begin
            m_id = (m_last + k) % N;
            break;
          end
        m_din = req_data[8*m_id +: 8];
        m_send = 1;
        ph = 1;
        tcnt = 0;
      end else if (ph == 1) begin
        tcnt++;
        if (tx_sent || (TO_EN && tcnt == 50)) begin
          m_terr = !tx_sent;
          m_send = 0;
          m_ack[m_id] = 1'b1;
          m_last = m_id;
          ph = 2;
        end
      end else if (ph == 2 && !tx_sent) ph = 0;
    end
    cyc++;
    #1;
    chk("tx_send", tx_send, m_send);
    chk("tx_din", tx_din, m_din);
    chk("grant_id", grant_id, m_id);
    chk("ack", ack, m_ack);
    chk("busy", busy, ph != 0);
    chk("timeout_err", timeout_err, m_terr);
    if (tx_send && !p_send) begin
      sent_q.push_back(tx_din);
      gap = cyc - ack_cyc;
      send_cyc = cyc;
    end
    if (ack != 0 && !p_ack) ack_cyc = cyc;
    if (ack != 0) ack_cnt++;
    if (timeout_err && !p_terr) to_gap = cyc - send_cyc;
    p_send = tx_send;
    p_ack = |ack;
    p_terr = timeout_err;
  end

  task automatic wait_acks(input int n, input int lim);
    int got = 0;
    for (int c = 0; c < lim && got < n; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        got++;
        req = req & (rearm | ~ack);
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL wait_acks: got %0d acks expected %0d", got, n);
    end
  endtask

  task automatic wait_send(input int lim);
    int c = 0;
    while (!tx_send && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (!tx_send) begin
      checks++; errors++;
      $display("FAIL wait_send: got tx_send=0 expected 1");
    end
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    while ((busy || tx_sent) && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (busy || tx_sent) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=%0b tx_sent=%0b expected 0 0", busy, tx_sent);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst tx_send", tx_send, 0);
    chk("rst tx_din", tx_din, 8'h00);
    chk("rst ack", ack, 0);
    chk("rst grant_id", grant_id, 0);
    chk("rst busy", busy, 0);
    reset = 1'b0;
    req_data[7:0] = 8'h41;
    req = 2'b01;
    wait_acks(1, 200);
    wait_idle(50);
    chk("single count", sent_q.size(), 1);
    chk("single byte", sent_q[0], 8'h41);
    chk("single ack cycles", ack_cnt, 1);
    chk("single busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sent_q.delete();
    req_data = {8'h42, 8'h41};
    rearm = 2'b11;
    req = 2'b11;
    wait_acks(4, 400);
    req = '0;
    rearm = '0;
    wait_idle(50);
    chk("rr count", sent_q.size(), 4);
    chk("rr byte0", sent_q[0], 8'h41);
    chk("rr byte1", sent_q[1], 8'h42);
    chk("rr byte2", sent_q[2], 8'h41);
    chk("rr byte3", sent_q[3], 8'h42);
    chk("b2b gap", gap, 2);
    sent_q.delete();
    req_data[7:0] = 8'h30;
    req = 2'b01;
    wait_send(50);
    @(negedge clk);
    req_data[7:0] = 8'h31;
    wait_acks(1, 200);
    wait_idle(50);
    chk("latched count", sent_q.size(), 1);
    chk("latched byte", sent_q[0], 8'h30);
    chk("latched din", tx_din, 8'h30);
    sent_q.delete();
    hold = 10;
    req_data = {8'h55, 8'h54};
    req = 2'b11;
    wait_acks(1, 200);
    wait_acks(1, 200);
    wait_idle(50);
    hold = 1;
    chk("slow count", sent_q.size(), 2);
    chk("slow byte0", sent_q[0], 8'h55);
    chk("slow byte1", sent_q[1], 8'h54);
    chk("slow gap", gap, 11);
    req_data[15:8] = 8'h66;
    req = 2'b10;
    wait_send(50);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst tx_send", tx_send, 0);
    chk("mid rst ack", ack, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst timeout_err", timeout_err, 0);
    sent_q.delete();
    req_data[7:0] = 8'h77;
    req = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_send(50);
    chk("post rst grant_id", grant_id, 0);
    chk("post rst tx_din", tx_din, 8'h77);
    wait_acks(2, 400);
    wait_idle(50);
    chk("post rst count", sent_q.size(), 2);
    chk("post rst byte1", sent_q[1], 8'h66);
`ifdef TX_ARBITER_TIMEOUT_EN
    never = 1'b1;
    sent_q.delete();
    req_data = {8'h92, 8'h91};
    req = 2'b11;
    wait_acks(1, 200);
    chk("timeout gap", to_gap, 50);
    wait_acks(1, 200);
    wait_idle(50);
    chk("timeout count", sent_q.size(), 2);
    chk("timeout byte0", sent_q[0], 8'h91);
    chk("timeout byte1", sent_q[1], 8'h92);
    never = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter sharing one UART transmitter (`tx`: `Send`/`Din`/`Sent` handshake) between `NUM_REQ` byte requesters, e.g. switch-driven send, message ROM, echo path. Sits between requesters and the `tx` instance in top-level designs. It latches the winning byte, drives the full Send/Sent handshake to completion, and returns a one-cycle acknowledge to the winner.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 120000: max cycles in SEND before abort; used only with the macro.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  request per requester; held until `ack`.
- `req_data`  in  8*NUM_REQ  byte for requester i at `[8i+7:8i]`; stable while `req[i]` is high.
- `ack`  out  NUM_REQ  one-cycle pulse: byte for requester i finished or aborted.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  index of current or last winner.
- `busy`  out  1  high whenever state is not IDLE.
- `tx_send`  out  1  to `tx.Send`.
- `tx_din`  out  8  to `tx.Din`; registered.
- `tx_sent`  in  1  from `tx.Sent`.
- `timeout_err`  out  1  one-cycle pulse on abort; constant 0 without the macro.

## Operation
- States: IDLE, SEND, RELEASE.
- IDLE: if any `req` is high, pick a winner round-robin, starting at `last+1` mod NUM_REQ. Register `grant_id`, register `tx_din <= req_data[winner]`, set `tx_send=1`, go to SEND.
- SEND: hold `tx_send`. On `tx_sent==1`: clear `tx_send`, pulse `ack[grant_id]`, set `last <= grant_id`, go to RELEASE.
- RELEASE: wait for `tx_sent==0`, then go to IDLE. No new `tx_send` is issued until `tx_sent` is low, so the `tx` handshake is always completed.
- Round-robin pointer `last` updates only on completion or abort. A requester that re-asserts immediately gets lowest priority relative to other pending requesters.
- `req` or `req_data` changes after grant have no effect on the byte in flight.
- A requester deasserting `req` before `ack` is a protocol violation. The byte still completes and is still acked.
- All outputs are registered. `busy` is decoded from the state register.

## Timing
- Reset values: state IDLE, `tx_send=0`, `tx_din=8'h00`, `ack=0`, `grant_id=0`, `timeout_err=0`, `last=NUM_REQ-1`, so requester 0 wins first after reset.
- Grant latency: `req` high at edge n in IDLE → `tx_send`, `tx_din`, `grant_id` valid after edge n.
- Completion: `tx_sent` high sampled at edge k → `tx_send` low and `ack` high for cycle k..k+1.
- Earliest RELEASE→IDLE transition is edge k+1. Earliest next arbitration is edge k+2.
- Requesters drop `req` by edge k+1 after seeing `ack`, so no double send occurs.
- Back-to-back bytes: minimum 3 cycles of overhead between `tx_sent` rising and the next `tx_send` rising.
- Reset asserted mid-transfer: immediate return to IDLE, `tx_send` low, no `ack` or `timeout_err` pulse. The in-flight byte is lost. The `tx` block shares `reset` and clears too.
- Simultaneous requests: the winner is the first set bit scanning upward from `last+1` with wrap-around.

## Configuration
- Macro: `TX_ARBITER_TIMEOUT_EN`.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to SEND and increments each SEND cycle.
  - When it reaches `TIMEOUT_CYCLES` without `tx_sent`: clear `tx_send`, pulse `ack[grant_id]` and `timeout_err`, update `last`, go to RELEASE.
  - `tx_sent` and timeout in the same cycle: treat as normal completion, no `timeout_err`.
- Undefined: no counter. SEND waits indefinitely. `timeout_err` is tied to 0.

## Structure
- Package `tx_arbiter_pkg`:
  - `typedef enum logic [1:0] {IDLE, SEND, RELEASE} tx_arb_state_t`
  - `localparam DATA_W = 8`
  - `localparam MAX_REQ = 8`
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_REQ]`, `last`.
  - Outputs: `winner` index, `any` flag.
  - Instantiated once.

## Test plan
Bench model: `tx` raises `Sent` 20 cycles after `Send` and drops it 1 cycle after `Send` falls.
- Single request: `req=2'b01`, `req_data[7:0]=8'h41` → `tx_din=8'h41`, one `tx_send` rise, `ack=2'b01` for exactly one cycle, `busy` low again after RELEASE.
- Simultaneous: `req=2'b11` (8'h41, 8'h42) held until each ack → bytes sent in order 41, 42. A second round with both still asserting alternates 41, 42, 41, 42.
- Data change after grant: change `req_data[i]` from 8'h30 to 8'h31 one cycle after grant → 8'h30 is transmitted.
- Slow Sent release: `tx_sent` held high 10 cycles after `tx_send` falls → no new `tx_send` until `tx_sent` is low, even with `req` pending.
- Reset mid-SEND: assert `reset` at cycle 5 of SEND → `tx_send=0` immediately, no `ack`, first grant after release is requester 0.
- With `TX_ARBITER_TIMEOUT_EN`, `TIMEOUT_CYCLES=50`, model never raises Sent → `timeout_err` and `ack` pulse at cycle 50 of SEND, `tx_send` drops, next requester is served.
